apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB3/APB4 requester that drives the apb_dpmem slave. Accepts one transfer at a time
//  on a valid/ready command port, runs the APB SETUP/ACCESS sequence and honours PREADY
//  wait states. Returns read data and error status on a single-cycle response pulse.
//  Sits between the system-side command source and the APB slave interface.
// PARAMETERS
//  ADDR_W          32  PADDR / cmd_addr width
//  DATA_W          32  PWDATA/PRDATA width, a multiple of 8
//  TIMEOUT_CYCLES  64  max ACCESS cycles with PREADY low before abort; 0 disables timeout
// PORTS
//  PCLK         in   1         clock
//  PRESETn      in   1         async active-low reset
//  cmd_valid    in   1         command request
//  cmd_ready    out  1         command accepted when valid&ready at PCLK rise
//  cmd_write    in   1         1=write, 0=read
//  cmd_addr     in   ADDR_W    byte address
//  cmd_wdata    in   DATA_W    write data
//  cmd_strb     in   DATA_W/8  write byte strobes
//  rsp_valid    out  1         one-cycle response pulse
//  rsp_rdata    out  DATA_W    read data; 0 for writes and timeouts
//  rsp_err      out  1         PSLVERR seen, or timeout
//  rsp_timeout  out  1         transfer aborted by timeout
//  PSEL         out  1         APB select
//  PENABLE      out  1         APB enable
//  PADDR        out  ADDR_W    APB address
//  PWRITE       out  1         APB direction
//  PWDATA       out  DATA_W    APB write data
//  PSTRB        out  DATA_W/8  APB strobes; 0 on reads
//  PRDATA       in   DATA_W    APB read data
//  PREADY       in   1         APB ready / wait-state control
//  PSLVERR      in   1         APB slave error
// BEHAVIOUR
//  - Reset: all registered outputs 0; state=IDLE; wait counter=0.
//  - cmd_ready = (state==IDLE), combinational. While in reset the flops are held, so no command is accepted.
//  - FSM IDLE->SETUP on cmd_valid&cmd_ready: latch addr/write/wdata/strb into the P* registers.
//  - PSTRB is forced to 0 for reads. PWDATA is unchanged on reads.
//  - SETUP: PSEL=1, PENABLE=0; unconditionally go to ACCESS next cycle.
//  - ACCESS: PSEL=1, PENABLE=1. P* outputs are stable for the whole ACCESS phase.
//  - ACCESS with PREADY=1: capture PRDATA (reads only) and PSLVERR. Next cycle: rsp_valid=1,
//    PSEL=0, PENABLE=0, state=IDLE.
//  - ACCESS with PREADY=0: increment wait counter. If TIMEOUT_CYCLES!=0 and the counter
//    reaches TIMEOUT_CYCLES, abort: next cycle rsp_valid=1, rsp_err=1, rsp_timeout=1,
//    rsp_rdata=0, PSEL=0, PENABLE=0, state=IDLE.
//  - Wait counter clears on entry to SETUP. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
//  - Latency: command accepted at edge N -> PSEL at N+1, PENABLE at N+2.
//    Zero-wait response pulse at N+3; cmd_ready=1 again at N+3.
//    Sustained throughput is one transfer per 3 cycles. No SETUP-from-ACCESS chaining.
//  - rsp_valid has no backpressure and is high for exactly one cycle. rsp_* hold their
//    values until the next response.
//  - Reset mid-transfer: PSEL and PENABLE drop immediately (async); no response is issued.
//  - PSLVERR is sampled only when PREADY=1 in ACCESS; it is ignored otherwise.
// STRUCTURE
//  - apb_pkg: apb_state_e {IDLE,SETUP,ACCESS} and the default ADDR_W/DATA_W localparams.
//  - Single module. The timeout counter stays inline; no sub-module is needed.
// TESTING
//  1 Zero-wait write 0x10=0xCAFEF00D, strb 0xF -> PSEL at N+1, PENABLE at N+2, rsp_valid at N+3, rsp_err=0.
//  2 Read 0x10 after test 1 -> rsp_rdata=0xCAFEF00D, PSTRB=0 during transfer, PWRITE=0.
//  3 Slave holds PREADY low 3 ACCESS cycles -> rsp_valid at N+6; PADDR/PWDATA stable throughout.
//  4 PSLVERR=1 with PREADY=1 on a read -> rsp_err=1, rsp_timeout=0.
//  5 TIMEOUT_CYCLES=16 with PREADY stuck low -> abort after 16 ACCESS cycles,
//    rsp_err=rsp_timeout=1, rsp_rdata=0.
//  6 Assert PRESETn low during ACCESS -> PSEL=PENABLE=0 at once; no rsp_valid;
//    next command after release runs normally.
//  Protocol checks (concurrent SVA) for every test:
//    PENABLE implies PSEL; SETUP is always followed by ACCESS;
//    P* stable while PSEL & !PREADY; exactly one rsp per accepted command.

Source files
------------

// File: rtl/apb_master_bridge_pkg.sv
// Shared types and defaults for the APB requester: FSM state encoding, bus widths,
// and the sizing rule for the wait-state counter.
package apb_master_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // A disabled timeout still needs a one-bit counter to keep the datapath legal.
  function automatic int cnt_width(input int timeout_cycles);
    return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response port and APB bus of the requester, bundled as one interface.
// The master modport is the bridge's view; the slave modport is the command source plus APB completer.
interface apb_master_bridge_if
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  localparam int STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              PSEL;
  logic              PENABLE;
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [STRB_W-1:0] PSTRB;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_master_bridge.sv
// APB3/APB4 requester, one transfer at a time; accept edge N -> PSEL N+1, PENABLE N+2, rsp pulse N+3+waits.
// cmd_ready only in IDLE; the rsp pulse has no backpressure; PREADY stalls ACCESS up to TIMEOUT_CYCLES.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_bridge_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = cnt_width(TIMEOUT_CYCLES);

  apb_state_e        state;
  apb_state_e        state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;
  logic              psel;
  logic              penable;
  logic              cmd_ready;
  logic              accept;
  logic              in_access;
  logic              timeout_hit;

  assign accept    = bus.cmd_valid && cmd_ready;
  assign in_access = (state == ACCESS);

  // Fires on the TIMEOUT_CYCLES-th stalled ACCESS cycle, i.e. as the counter reaches the limit.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_access && !bus.PREADY &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (bus.PREADY || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psel      = 1'b0;
    penable   = 1'b0;
    cmd_ready = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      SETUP:   psel      = 1'b1;
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      default: ;
    endcase
  end

  // Address phase registers change only on acceptance, so they hold through every wait state.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      wait_cnt <= '0;
    end else if (accept) begin
      paddr_q  <= bus.cmd_addr;
      pwrite_q <= bus.cmd_write;
      if (bus.cmd_write) pwdata_q <= bus.cmd_wdata;
      pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
      wait_cnt <= '0;
    end else if (in_access && !bus.PREADY) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (in_access && bus.PREADY) begin
        rsp_valid_q   <= 1'b1;
        rsp_rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
        rsp_err_q     <= bus.PSLVERR;
        rsp_timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        rsp_valid_q   <= 1'b1;
        rsp_rdata_q   <= '0;
        rsp_err_q     <= 1'b1;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.PSEL        = psel;
  assign bus.PENABLE     = penable;
  assign bus.PADDR       = paddr_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: table of transfers against a small APB memory completer,
// response scoreboard with latency, a reset-during-ACCESS sequence and protocol assertions.
module tb_apb_master_bridge;
  import apb_master_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [31:0] NOISE = 32'hDEAD_BEEF;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    bit          slverr;
    bit          stuck;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          exp_to;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          to;
    int          lat;
    int          acc;
  } exp_t;

  logic PCLK;
  logic PRESETn;

  apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_bridge #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          slave_waits = 0;
  bit          slave_err = 0;
  bit          slave_stuck = 0;
  logic [31:0] mem [16];
  logic [31:0] last_wdata = '0;
  exp_t        sb [$];
  vec_t        vecs [13];

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] wdata, logic [3:0] strb,
                              int waits, bit slverr, bit stuck, logic [31:0] er, bit ee, bit et,
                              int lat);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.waits = waits; v.slverr = slverr; v.stuck = stuck;
    v.exp_rdata = er; v.exp_err = ee; v.exp_to = et; v.exp_lat = lat;
    return v;
  endfunction

  // APB completer: word memory, programmable wait states, PSLVERR noise while stalling.
  initial begin
    int acc_cnt;
    int idx;
    acc_cnt = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = NOISE;
    forever begin
      @(negedge PCLK);
      if (PRESETn && bus.PSEL && bus.PENABLE) begin
        if (slave_stuck || acc_cnt < slave_waits) begin
          bus.PREADY  = 1'b0;
          bus.PSLVERR = 1'b1;
          bus.PRDATA  = NOISE;
          acc_cnt++;
        end else begin
          idx = int'(bus.PADDR[5:2]);
          bus.PREADY  = 1'b1;
          bus.PSLVERR = slave_err;
          if (bus.PWRITE) begin
            bus.PRDATA = NOISE;
            if (!slave_err)
              for (int b = 0; b < 4; b++)
                if (bus.PSTRB[b]) mem[idx][8*b +: 8] = bus.PWDATA[8*b +: 8];
          end else begin
            bus.PRDATA = mem[idx];
          end
          acc_cnt = 0;
        end
      end else begin
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = NOISE;
        acc_cnt = 0;
      end
    end
  end

  // Response monitor: every pulse must match the oldest outstanding expectation.
  initial forever begin
    exp_t e;
    @(negedge PCLK);
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.to));
        chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  a_pen_psel: assert property (@(posedge PCLK) disable iff (!PRESETn)
    bus.PENABLE |-> bus.PSEL)
    else begin errors++; $display("FAIL sva_penable_without_psel"); end

  a_setup_access: assert property (@(posedge PCLK) disable iff (!PRESETn)
    (bus.PSEL && !bus.PENABLE) |=> (bus.PSEL && bus.PENABLE))
    else begin errors++; $display("FAIL sva_setup_not_followed_by_access"); end

  a_stable: assert property (@(posedge PCLK) disable iff (!PRESETn)
    (bus.PSEL && !bus.PREADY) |=> ($stable(bus.PADDR) && $stable(bus.PWRITE) &&
                                   $stable(bus.PWDATA) && $stable(bus.PSTRB)))
    else begin errors++; $display("FAIL sva_pbus_unstable_during_wait"); end

  task automatic drive_cmd(input vec_t v);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_strb  = v.strb;
    if (v.wr) last_wdata = v.wdata;
    @(posedge PCLK);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = $urandom();
    bus.cmd_wdata = $urandom();
    bus.cmd_strb  = 4'($urandom());
  endtask

  task automatic run_cmd(input vec_t v, input string nm);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge PCLK);
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge PCLK);
      guard++;
    end
    chk({nm, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    slave_waits = v.waits;
    slave_err   = v.slverr;
    slave_stuck = v.stuck;
    drive_cmd(v);
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.to = v.exp_to;
    e.lat = v.exp_lat; e.acc = cyc;
    sb.push_back(e);
    @(negedge PCLK);
    chk({nm, "_setup_psel"}, 32'(bus.PSEL), 32'd1);
    chk({nm, "_setup_penable"}, 32'(bus.PENABLE), 32'd0);
    chk({nm, "_busy_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    chk({nm, "_paddr"}, bus.PADDR, v.addr);
    chk({nm, "_pwrite"}, 32'(bus.PWRITE), 32'(v.wr));
    chk({nm, "_pstrb"}, 32'(bus.PSTRB), v.wr ? 32'(v.strb) : 32'd0);
    @(negedge PCLK);
    chk({nm, "_access_penable"}, 32'(bus.PENABLE), 32'd1);
    chk({nm, "_pwdata"}, bus.PWDATA, last_wdata);
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge PCLK);
      guard++;
    end
    chk({nm, "_rsp_outstanding"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vec_t rv;
    PRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;

    //               wr addr       wdata         strb  wt  err stk exp_rdata     ee  et  lat
    vecs[0]  = mk(1, 32'h10, 32'hCAFEF00D, 4'hF,  0, 0, 0, 32'h0,        0, 0, 2);
    vecs[1]  = mk(0, 32'h10, 32'h0,        4'hF,  0, 0, 0, 32'hCAFEF00D, 0, 0, 2);
    vecs[2]  = mk(1, 32'h14, 32'h12345678, 4'hF,  3, 0, 0, 32'h0,        0, 0, 5);
    vecs[3]  = mk(0, 32'h14, 32'h0,        4'h0,  3, 0, 0, 32'h12345678, 0, 0, 5);
    vecs[4]  = mk(1, 32'h10, 32'hAAAA5555, 4'h3,  1, 0, 0, 32'h0,        0, 0, 3);
    vecs[5]  = mk(0, 32'h10, 32'h0,        4'hC,  0, 0, 0, 32'hCAFE5555, 0, 0, 2);
    vecs[6]  = mk(0, 32'h14, 32'h0,        4'h0,  0, 1, 0, 32'h12345678, 1, 0, 2);
    vecs[7]  = mk(1, 32'h18, 32'h11112222, 4'hF,  2, 1, 0, 32'h0,        1, 0, 4);
    vecs[8]  = mk(0, 32'h18, 32'h0,        4'h0,  0, 0, 0, 32'h0,        0, 0, 2);
    vecs[9]  = mk(0, 32'h14, 32'h0,        4'h0, 15, 0, 0, 32'h12345678, 0, 0, 17);
    vecs[10] = mk(0, 32'h20, 32'h0,        4'h0,  0, 0, 1, 32'h0,        1, 1, 17);
    vecs[11] = mk(1, 32'h1C, 32'h00000055, 4'hF,  0, 0, 1, 32'h0,        1, 1, 17);
    vecs[12] = mk(0, 32'h1C, 32'h0,        4'h0,  0, 0, 0, 32'h0,        0, 0, 2);

    repeat (3) @(negedge PCLK);
    chk("reset_psel", 32'(bus.PSEL), 32'd0);
    chk("reset_penable", 32'(bus.PENABLE), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_paddr", bus.PADDR, 32'd0);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    PRESETn = 1'b1;

    for (int i = 0; i < 13; i++) run_cmd(vecs[i], $sformatf("v%0d", i));

    // Reset while a read is stalled in ACCESS: bus drops asynchronously, no response follows.
    @(negedge PCLK);
    slave_stuck = 1'b1;
    rv = mk(0, 32'h10, 32'h0, 4'h0, 0, 0, 1, 32'h0, 0, 0, 0);
    drive_cmd(rv);
    repeat (3) @(negedge PCLK);
    chk("pre_reset_penable", 32'(bus.PENABLE), 32'd1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("midreset_psel", 32'(bus.PSEL), 32'd0);
    chk("midreset_penable", 32'(bus.PENABLE), 32'd0);
    repeat (3) @(negedge PCLK);
    chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midreset_pwdata", bus.PWDATA, 32'd0);
    slave_stuck = 1'b0;
    last_wdata  = '0;
    PRESETn     = 1'b1;
    run_cmd(mk(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 32'hCAFE5555, 0, 0, 2), "after_reset");

    repeat (5) @(negedge PCLK);
    chk("final_outstanding", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
